control_unit: RTL and testbench

Multicycle sequencer for the MIPS CPU datapath. Decodes the instruction register's opcode/funct fields and drives every load enable, write strobe and mux select of the datapath (PC, IR, MDR, A/B, ALUOut, EPC, register bank, memory) one state per cycle. Sits beside the datapath inside `CPU`; handles memory wait cycles, branch resolution and overflow/invalid-opcode exceptions.

---
 rtl/cpu_ctrl_pkg.sv | 75 +++++++
 rtl/control_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: the state
// encoding, the opcode/funct values it decodes, and the select codes it
// drives into the datapath.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET, ST_FETCH, ST_DECODE, ST_R_EXEC,
        ST_R_WB, ST_ADDI_EXEC, ST_I_WB, ST_MEM_ADDR,
        ST_LW_READ, ST_LW_WB, ST_SW_WRITE, ST_BRANCH,
        ST_JUMP, ST_JAL, ST_JR, ST_EXC
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    // ula32 function codes
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    // Datapath mux encodings
    localparam logic       IORD_PC      = 1'b0;
    localparam logic       IORD_ALUOUT  = 1'b1;
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_A       = 1'b1;
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
    localparam logic [1:0] PCS_ALU      = 2'b00;
    localparam logic [1:0] PCS_ALUOUT   = 2'b01;
    localparam logic [1:0] PCS_JUMP     = 2'b10;
    localparam logic [1:0] PCS_EXC      = 2'b11;
    localparam logic [1:0] RDST_RT      = 2'b00;
    localparam logic [1:0] RDST_RD      = 2'b01;
    localparam logic [1:0] RDST_SP      = 2'b10;
    localparam logic [1:0] RDST_RA      = 2'b11;
    localparam logic [1:0] M2R_ALUOUT   = 2'b00;
    localparam logic [1:0] M2R_MDR      = 2'b01;
    localparam logic [1:0] M2R_SP_INIT  = 2'b10;
    localparam logic [1:0] M2R_PC       = 2'b11;
    localparam logic       EXC_INVALID  = 1'b0;
    localparam logic       EXC_OVF      = 1'b1;

    // Value the datapath constant mux writes into $29 on reset
    localparam int SP_INIT = 227;

    // ALU function for the four arithmetic/logic R-type instructions
    function automatic logic [2:0] funct_alu_op(input logic [5:0] f);
        case (f)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_XOR:  return ALU_XOR;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle sequencer for the MIPS datapath. One state per cycle; the
// fetch and load states hold for MEM_WAIT extra cycles using an inline
// wait counter. Outputs are decoded from state and counter and are forced
// to zero while reset is asserted so an aborted access cannot complete.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       zero,
    output logic       PC_write,
    output logic       ir_load,
    output logic       mdr_load,
    output logic       AB_load,
    output logic       aluout_load,
    output logic       EPC_load,
    output logic       reg_write,
    output logic       wr,
    output logic       sel_iord,
    output logic       sel_alusrca,
    output logic [1:0] sel_alusrcb,
    output logic [2:0] alu_op,
    output logic [1:0] sel_pcsource,
    output logic [1:0] sel_regdst,
    output logic [1:0] sel_memtoreg,
    output logic       exc_sel
);

    localparam int              CW       = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(MEM_WAIT);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          exc_q, exc_d;

    logic cnt_last;
    logic is_rtype_alu;
    logic is_rtype_arith;

    assign cnt_last       = (cnt_q == CNT_LAST);
    assign is_rtype_arith = (funct == FN_ADD) || (funct == FN_SUB);
    assign is_rtype_alu   = is_rtype_arith || (funct == FN_AND) || (funct == FN_XOR);

    // Next-state, wait-counter and exception-cause selection
    always_comb begin
        state_d = ST_FETCH;
        cnt_d   = '0;
        exc_d   = exc_q;
        case (state_q)
            ST_FETCH: begin
                if (cnt_last) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            state_d = ST_JR;
                        end else if (is_rtype_alu) begin
                            state_d = ST_R_EXEC;
                        end else begin
                            state_d = ST_EXC;
                            exc_d   = EXC_INVALID;
                        end
                    end
                    OP_ADDI:      state_d = ST_ADDI_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_JAL:       state_d = ST_JAL;
                    default: begin
                        state_d = ST_EXC;
                        exc_d   = EXC_INVALID;
                    end
                endcase
            end
            ST_R_EXEC: begin
                if (is_rtype_arith && overflow) begin
                    state_d = ST_EXC;
                    exc_d   = EXC_OVF;
                end else begin
                    state_d = ST_R_WB;
                end
            end
            ST_ADDI_EXEC: begin
                if (overflow) begin
                    state_d = ST_EXC;
                    exc_d   = EXC_OVF;
                end else begin
                    state_d = ST_I_WB;
                end
            end
            ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_LW_READ : ST_SW_WRITE;
            ST_LW_READ: begin
                if (cnt_last) begin
                    state_d = ST_LW_WB;
                end else begin
                    state_d = ST_LW_READ;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // State, counter and exception-cause registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            exc_q   <= EXC_INVALID;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
        end
    end

    // Moore decode of strobes and selects; BRANCH alone looks at zero
    always_comb begin
        PC_write     = 1'b0;
        ir_load      = 1'b0;
        mdr_load     = 1'b0;
        AB_load      = 1'b0;
        aluout_load  = 1'b0;
        EPC_load     = 1'b0;
        reg_write    = 1'b0;
        wr           = 1'b0;
        sel_iord     = IORD_PC;
        sel_alusrca  = SRCA_PC;
        sel_alusrcb  = SRCB_B;
        alu_op       = ALU_PASS;
        sel_pcsource = PCS_ALU;
        sel_regdst   = RDST_RT;
        sel_memtoreg = M2R_ALUOUT;
        exc_sel      = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_RESET: begin
                    reg_write    = 1'b1;
                    sel_regdst   = RDST_SP;
                    sel_memtoreg = M2R_SP_INIT;
                end
                ST_FETCH: begin
                    sel_alusrcb = SRCB_FOUR;
                    alu_op      = ALU_ADD;
                    ir_load     = cnt_last;
                    PC_write    = cnt_last;
                end
                ST_DECODE: begin
                    AB_load     = 1'b1;
                    aluout_load = 1'b1;
                    sel_alusrcb = SRCB_IMM_SH2;
                    alu_op      = ALU_ADD;
                end
                ST_R_EXEC: begin
                    sel_alusrca = SRCA_A;
                    alu_op      = funct_alu_op(funct);
                    aluout_load = 1'b1;
                end
                ST_R_WB: begin
                    reg_write  = 1'b1;
                    sel_regdst = RDST_RD;
                end
                ST_ADDI_EXEC, ST_MEM_ADDR: begin
                    sel_alusrca = SRCA_A;
                    sel_alusrcb = SRCB_IMM;
                    alu_op      = ALU_ADD;
                    aluout_load = 1'b1;
                end
                ST_I_WB: reg_write = 1'b1;
                ST_LW_READ: begin
                    sel_iord = IORD_ALUOUT;
                    mdr_load = cnt_last;
                end
                ST_LW_WB: begin
                    reg_write    = 1'b1;
                    sel_memtoreg = M2R_MDR;
                end
                ST_SW_WRITE: begin
                    sel_iord = IORD_ALUOUT;
                    wr       = 1'b1;
                end
                ST_BRANCH: begin
                    sel_alusrca  = SRCA_A;
                    alu_op       = ALU_SUB;
                    sel_pcsource = PCS_ALUOUT;
                    PC_write     = (opcode == OP_BEQ) ? zero : ~zero;
                end
                ST_JUMP: begin
                    PC_write     = 1'b1;
                    sel_pcsource = PCS_JUMP;
                end
                ST_JAL: begin
                    PC_write     = 1'b1;
                    sel_pcsource = PCS_JUMP;
                    reg_write    = 1'b1;
                    sel_regdst   = RDST_RA;
                    sel_memtoreg = M2R_PC;
                end
                ST_JR: begin
                    sel_alusrca = SRCA_A;
                    alu_op      = ALU_PASS;
                    PC_write    = 1'b1;
                end
                ST_EXC: begin
                    sel_alusrcb  = SRCB_FOUR;
                    alu_op       = ALU_SUB;
                    EPC_load     = 1'b1;
                    PC_write     = 1'b1;
                    sel_pcsource = PCS_EXC;
                    exc_sel      = exc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomised scoreboard bench for control_unit. A reference model expands
// each instruction into the per-cycle control word sequence it should
// produce; a monitor compares every cycle on the falling edge.
module tb_control_unit;

    localparam int MW = 2;

    typedef struct packed {
        logic       pcw, irl, mdrl, abl, aol, epcl, rw, wr, iord, srca;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic [1:0] pcs, rdst, m2r;
        logic       exc;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       overflow, zero;
    logic       PC_write, ir_load, mdr_load, AB_load, aluout_load, EPC_load, reg_write, wr;
    logic       sel_iord, sel_alusrca, exc_sel;
    logic [1:0] sel_alusrcb, sel_pcsource, sel_regdst, sel_memtoreg;
    logic [2:0] alu_op;

    ctl_t act_w;
    ctl_t sb_q[$];
    ctl_t mq[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    control_unit #(.MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .overflow(overflow), .zero(zero),
        .PC_write(PC_write), .ir_load(ir_load), .mdr_load(mdr_load),
        .AB_load(AB_load), .aluout_load(aluout_load), .EPC_load(EPC_load),
        .reg_write(reg_write), .wr(wr), .sel_iord(sel_iord),
        .sel_alusrca(sel_alusrca), .sel_alusrcb(sel_alusrcb), .alu_op(alu_op),
        .sel_pcsource(sel_pcsource), .sel_regdst(sel_regdst),
        .sel_memtoreg(sel_memtoreg), .exc_sel(exc_sel)
    );

    assign act_w = {PC_write, ir_load, mdr_load, AB_load, aluout_load, EPC_load,
                    reg_write, wr, sel_iord, sel_alusrca, sel_alusrcb, alu_op,
                    sel_pcsource, sel_regdst, sel_memtoreg, exc_sel};

    task automatic chk(input string name, input ctl_t act, input ctl_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (opcode=%h funct=%h ovf=%b zero=%b t=%0t)",
                     name, act, exp, opcode, funct, overflow, zero, $time);
        end
    endtask

    // Reference model: control words the instruction should emit, in order
    function automatic ctl_t exc_word(input logic cause);
        ctl_t c = '0;
        c.epcl = 1'b1; c.pcw = 1'b1; c.pcs = 2'd3; c.srcb = 2'd1; c.alu = 3'd2; c.exc = cause;
        return c;
    endfunction

    task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic z);
        ctl_t c;
        bit   arith, rlogic;
        mq = {};
        for (int i = 0; i <= MW; i++) begin
            c = '0; c.srcb = 2'd1; c.alu = 3'd1;
            if (i == MW) begin c.irl = 1'b1; c.pcw = 1'b1; end
            mq.push_back(c);
        end
        c = '0; c.abl = 1'b1; c.aol = 1'b1; c.srcb = 2'd3; c.alu = 3'd1;
        mq.push_back(c);
        arith  = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22);
        rlogic = (op == 6'h00) && (fn == 6'h24 || fn == 6'h26);
        if (op == 6'h00 && fn == 6'h08) begin
            c = '0; c.srca = 1'b1; c.pcw = 1'b1;
            mq.push_back(c);
        end else if (arith || rlogic) begin
            c = '0; c.srca = 1'b1; c.aol = 1'b1;
            c.alu = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : (fn == 6'h24) ? 3'd3 : 3'd6;
            mq.push_back(c);
            if (arith && ovf) mq.push_back(exc_word(1'b1));
            else begin c = '0; c.rw = 1'b1; c.rdst = 2'd1; mq.push_back(c); end
        end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
            c = '0; c.srca = 1'b1; c.srcb = 2'd2; c.alu = 3'd1; c.aol = 1'b1;
            mq.push_back(c);
            if (op == 6'h08) begin
                if (ovf) mq.push_back(exc_word(1'b1));
                else begin c = '0; c.rw = 1'b1; mq.push_back(c); end
            end else if (op == 6'h23) begin
                for (int i = 0; i <= MW; i++) begin
                    c = '0; c.iord = 1'b1; c.mdrl = (i == MW);
                    mq.push_back(c);
                end
                c = '0; c.rw = 1'b1; c.m2r = 2'd1; mq.push_back(c);
            end else begin
                c = '0; c.iord = 1'b1; c.wr = 1'b1; mq.push_back(c);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            c = '0; c.srca = 1'b1; c.alu = 3'd2; c.pcs = 2'd1;
            c.pcw = (op == 6'h04) ? z : !z;
            mq.push_back(c);
        end else if (op == 6'h02 || op == 6'h03) begin
            c = '0; c.pcw = 1'b1; c.pcs = 2'd2;
            if (op == 6'h03) begin c.rw = 1'b1; c.rdst = 2'd3; c.m2r = 2'd3; end
            mq.push_back(c);
        end else begin
            mq.push_back(exc_word(1'b0));
        end
    endtask

    // Leave reset at posedge+1; the following cycle is the RESET state
    task automatic release_reset();
        ctl_t c = '0;
        c.rw = 1'b1; c.rdst = 2'd2; c.m2r = 2'd2;
        reset = 1'b0;
        sb_q.push_back(c);
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic z);
        int n;
        opcode = op; funct = fn; overflow = ovf; zero = z;
        model(op, fn, ovf, z);
        n = mq.size();
        foreach (mq[i]) sb_q.push_back(mq[i]);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Run k cycles of an instruction, then assert reset inside cycle k
    task automatic abort_at(input string name, input logic [5:0] op, input int k);
        ctl_t zw = '0;
        opcode = op; funct = 6'h00; overflow = 1'b0; zero = 1'b0;
        model(op, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < k; i++) sb_q.push_back(mq[i]);
        repeat (k) @(posedge clk);
        #1;
        chk({name, "_before_reset"}, act_w, mq[k]);
        reset = 1'b1;
        #1;
        chk({name, "_async_drop"}, act_w, zw);
        @(posedge clk); #1;
        chk({name, "_held_reset"}, act_w, zw);
        release_reset();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && sb_q.size() > 0) chk("cycle_ctl", act_w, sb_q.pop_front());
    end

    initial begin
        logic [5:0] op, fn;
        int         sel;
        reset = 1'b1; opcode = 6'h00; funct = 6'h20; overflow = 1'b0; zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", act_w, '0);
        release_reset();

        run(6'h00, 6'h20, 1'b0, 1'b0);   // add
        run(6'h00, 6'h20, 1'b1, 1'b0);   // add overflow
        run(6'h00, 6'h22, 1'b1, 1'b1);   // sub overflow
        run(6'h00, 6'h24, 1'b1, 1'b0);   // and ignores overflow
        run(6'h00, 6'h26, 1'b0, 1'b1);   // xor
        run(6'h00, 6'h08, 1'b0, 1'b0);   // jr
        run(6'h00, 6'h3F, 1'b0, 1'b0);   // bad funct
        run(6'h08, 6'h11, 1'b0, 1'b0);   // addi
        run(6'h08, 6'h11, 1'b1, 1'b0);   // addi overflow
        run(6'h23, 6'h00, 1'b0, 1'b0);   // lw
        run(6'h2B, 6'h00, 1'b0, 1'b0);   // sw
        run(6'h04, 6'h00, 1'b0, 1'b1);   // beq taken
        run(6'h04, 6'h00, 1'b0, 1'b0);   // beq not taken
        run(6'h05, 6'h00, 1'b0, 1'b1);   // bne not taken
        run(6'h05, 6'h00, 1'b0, 1'b0);   // bne taken
        run(6'h02, 6'h00, 1'b0, 1'b0);   // j
        run(6'h03, 6'h00, 1'b0, 1'b0);   // jal
        run(6'h3F, 6'h00, 1'b0, 1'b0);   // invalid opcode

        abort_at("lw_abort", 6'h23, MW + 3 + MW);
        run(6'h00, 6'h20, 1'b0, 1'b0);
        abort_at("sw_abort", 6'h2B, MW + 3);
        run(6'h23, 6'h00, 1'b0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            sel = $urandom_range(0, 9);
            fn  = 6'($urandom);
            case (sel)
                0: begin
                    op = 6'h00;
                    case ($urandom_range(0, 4))
                        0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h26;
                        default: fn = 6'h08;
                    endcase
                end
                1: op = 6'h08;
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                5: op = 6'h05;
                6: op = 6'h02;
                7: op = 6'h03;
                8: op = 6'($urandom);
                default: op = 6'h00;
            endcase
            run(op, fn, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
